merge_stream_unit: RTL and testbench

MERGE_STREAM_UNIT -- requirements
Module: merge_stream_unit

---
 rtl/sort_pkg.sv | 17 +
 rtl/merge_stream_unit_if.sv | 15 +
 rtl/key_compare.sv | 18 +
 rtl/merge_stream_unit.sv | 184 ++++++++++++++++++
 tb/tb_merge_stream_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the two-run merge stream unit: FSM state encoding,
// default widths and the key ordering selectors.
package sort_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

  localparam int ORDER_ASC  = 0;
  localparam int ORDER_DESC = 1;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } merge_state_t;

endpackage

// File: rtl/merge_stream_unit_if.sv
// Valid/ready stream carrying one key per transfer plus a last-of-run marker.
// The master drives data/valid/last, the slave drives ready.
interface merge_stream_unit_if #(
  parameter int DATA_W = sort_pkg::DEFAULT_DATA_W
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/key_compare.sv
// Ordering predicate shared by the merge selector and the run order checks:
// take_a is high when a belongs at or before b in the configured order,
// so equal keys always favour a.
module key_compare #(
  parameter int DATA_W = sort_pkg::DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              descending,
  output logic              take_a
);

  // Non-strict compare keeps ties stable in favour of a.
  always_comb begin
    take_a = descending ? (a >= b) : (a <= b);
  end

endmodule

// File: rtl/merge_stream_unit.sv
// Merges two sorted input runs into one sorted output run, one element per
// cycle, with a single output register, a per-run element counter and a
// sticky flag for non-monotonic input runs.
module merge_stream_unit
  import sort_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DESCENDING = ORDER_ASC,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  merge_stream_unit_if.slave   a,
  merge_stream_unit_if.slave   b,
  merge_stream_unit_if.master  out,
  output logic [CNT_W-1:0]     run_count,
  output logic                 order_err
);

  localparam logic DESC = (DESCENDING == ORDER_DESC);

  merge_state_t      state;

  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic [DATA_W-1:0] a_prev;
  logic [DATA_W-1:0] b_prev;
  logic              a_first;
  logic              b_first;

  logic              adv;
  logic              take_a;
  logic              a_ok;
  logic              b_ok;
  logic              pop_a;
  logic              pop_b;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ends_pair;
  logic              out_fire;

  // Head-to-head selection between the two runs.
  key_compare #(.DATA_W(DATA_W)) u_select (
    .a          (a.data),
    .b          (b.data),
    .descending (DESC),
    .take_a     (take_a)
  );

  // Previous key of a run must sit at or before the key being popped.
  key_compare #(.DATA_W(DATA_W)) u_check_a (
    .a          (a_prev),
    .b          (a.data),
    .descending (DESC),
    .take_a     (a_ok)
  );

  key_compare #(.DATA_W(DATA_W)) u_check_b (
    .a          (b_prev),
    .b          (b.data),
    .descending (DESC),
    .take_a     (b_ok)
  );

  assign out_fire = out_valid_q & out.ready;

  // Pop decision: only while the output slot is free or being vacated,
  // never during reset, and at most one side per cycle.
  always_comb begin
    adv   = ena & (~out_valid_q | out.ready);
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (!rst) begin
      case (state)
        MERGE: begin
          if (a.valid & b.valid & adv) begin
            pop_a = take_a;
            pop_b = ~take_a;
          end
        end
        DRAIN_A: pop_a = a.valid & adv;
        DRAIN_B: pop_b = b.valid & adv;
        default: begin
          pop_a = 1'b0;
          pop_b = 1'b0;
        end
      endcase
    end
  end

  // Element entering the output register and whether it closes the pair.
  always_comb begin
    pop_data      = pop_a ? a.data : b.data;
    pop_ends_pair = ((state == DRAIN_A) & pop_a & a.last) |
                    ((state == DRAIN_B) & pop_b & b.last);
  end

  assign a.ready = pop_a;
  assign b.ready = pop_b;

  assign out.data  = out_data_q;
  assign out.valid = out_valid_q;
  assign out.last  = out_last_q;

  // Run sequencing: the side whose last element leaves MERGE first hands
  // over to draining the other side; that side's last element ends the pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MERGE;
    end else begin
      case (state)
        MERGE: begin
          if (pop_a & a.last) begin
            state <= DRAIN_B;
          end else if (pop_b & b.last) begin
            state <= DRAIN_A;
          end
        end
        DRAIN_A: if (pop_a & a.last) state <= MERGE;
        DRAIN_B: if (pop_b & b.last) state <= MERGE;
        default: state <= MERGE;
      endcase
    end
  end

  // Output register: a pop overwrites it even when the current element is
  // leaving in the same cycle, giving back-to-back transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (pop_a | pop_b) begin
      out_valid_q <= 1'b1;
      out_data_q  <= pop_data;
      out_last_q  <= pop_ends_pair;
    end else if (out.ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  // Count elements handed downstream; the closing element restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_count <= '0;
    end else if (out_fire) begin
      if (out_last_q) begin
        run_count <= '0;
      end else begin
        run_count <= run_count + 1'b1;
      end
    end
  end

  // Per-input monotonicity tracking; the first element of each run is exempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev    <= '0;
      b_prev    <= '0;
      a_first   <= 1'b1;
      b_first   <= 1'b1;
      order_err <= 1'b0;
    end else begin
      if (pop_a) begin
        a_prev  <= a.data;
        a_first <= a.last;
        if (!a_first && !a_ok) begin
          order_err <= 1'b1;
        end
      end
      if (pop_b) begin
        b_prev  <= b.data;
        b_first <= b.last;
        if (!b_first && !b_ok) begin
          order_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_merge_stream_unit.sv
// Directed bench for merge_stream_unit: an ascending instance fed from small
// source queues, plus a descending instance driven by hand.
module tb_merge_stream_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [15:0] run_count;
  logic        order_err;
  logic [15:0] rcd;
  logic        oed;

  always #5 clk = ~clk;

  merge_stream_unit_if #(.DATA_W(32)) a_if ();
  merge_stream_unit_if #(.DATA_W(32)) b_if ();
  merge_stream_unit_if #(.DATA_W(32)) o_if ();
  merge_stream_unit_if #(.DATA_W(32)) ad_if ();
  merge_stream_unit_if #(.DATA_W(32)) bd_if ();
  merge_stream_unit_if #(.DATA_W(32)) od_if ();

  merge_stream_unit #(.DATA_W(32), .DESCENDING(0), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .a         (a_if),
    .b         (b_if),
    .out       (o_if),
    .run_count (run_count),
    .order_err (order_err)
  );

  merge_stream_unit #(.DATA_W(32), .DESCENDING(1), .CNT_W(16)) dut_desc (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .a         (ad_if),
    .b         (bd_if),
    .out       (od_if),
    .run_count (rcd),
    .order_err (oed)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } elem_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] cnt;
  } xfer_t;

  elem_t a_q [$];
  elem_t b_q [$];
  xfer_t log_q [$];
  bit    pop_q [$];
  logic  a_en = 1'b0;
  logic  b_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic l);
    elem_t e;
    e.data = d;
    e.last = l;
    a_q.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input logic l);
    elem_t e;
    e.data = d;
    e.last = l;
    b_q.push_back(e);
  endtask

  task automatic drive();
    a_if.valid = a_en && (a_q.size() > 0);
    a_if.data  = (a_q.size() > 0) ? a_q[0].data : 32'd0;
    a_if.last  = (a_q.size() > 0) ? a_q[0].last : 1'b0;
    b_if.valid = b_en && (b_q.size() > 0);
    b_if.data  = (b_q.size() > 0) ? b_q[0].data : 32'd0;
    b_if.last  = (b_q.size() > 0) ? b_q[0].last : 1'b0;
  endtask

  // One clock: handshakes sampled mid-cycle, sources advanced after the edge.
  task automatic tick();
    logic  af;
    logic  bf;
    xfer_t x;
    @(negedge clk);
    af = a_if.valid & a_if.ready;
    bf = b_if.valid & b_if.ready;
    if (o_if.valid & o_if.ready) begin
      x.data = o_if.data;
      x.last = o_if.last;
      x.cnt  = run_count;
      log_q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (af) begin
      a_q.delete(0);
      pop_q.push_back(1'b1);
    end
    if (bf) begin
      b_q.delete(0);
      pop_q.push_back(1'b0);
    end
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input string tag);
    int k;
    k = 0;
    while ((log_q.size() < n) && (k < 60)) begin
      tick();
      k++;
    end
    chk({tag, " transfers"}, 32'(log_q.size()), 32'(n));
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] ed [8]);
    for (int i = 0; i < n; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("%s data[%0d]", tag, i), log_q[i].data, ed[i]);
        chk($sformatf("%s last[%0d]", tag, i), 32'(log_q[i].last), 32'(i == n - 1));
        chk($sformatf("%s cnt[%0d]", tag, i), 32'(log_q[i].cnt), 32'(i));
      end
    end
    log_q.delete();
    pop_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ed [8];

    ad_if.valid = 1'b0; ad_if.data = '0; ad_if.last = 1'b0;
    bd_if.valid = 1'b0; bd_if.data = '0; bd_if.last = 1'b0;
    od_if.ready = 1'b1;
    o_if.ready  = 1'b1;
    ena  = 1'b1;
    a_en = 1'b1;
    b_en = 1'b1;

    // Basic merge, loaded while still in reset
    push_a(1, 0); push_a(4, 0); push_a(9, 1);
    push_b(2, 0); push_b(3, 0); push_b(10, 1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(o_if.valid), 0);
    chk("rst out_data", o_if.data, 0);
    chk("rst out_last", 32'(o_if.last), 0);
    chk("rst run_count", 32'(run_count), 0);
    chk("rst order_err", 32'(order_err), 0);
    chk("rst a_ready", 32'(a_if.ready), 0);
    chk("rst b_ready", 32'(b_if.ready), 0);
    rst = 1'b0;
    #1;
    chk("first a_ready", 32'(a_if.ready), 1);
    chk("first b_ready", 32'(b_if.ready), 0);
    run_until(6, "basic");
    chk("basic run_count end", 32'(run_count), 0);
    chk("basic order_err", 32'(order_err), 0);
    ed = '{1, 2, 3, 4, 9, 10, 0, 0};
    check_log("basic", 6, ed);

    // Equal keys: A wins ties
    push_a(5, 0); push_a(5, 1);
    push_b(5, 1);
    drive();
    #1;
    run_until(3, "tie");
    chk("tie pops", 32'(pop_q.size()), 3);
    if (pop_q.size() == 3) begin
      chk("tie pop0 is A", 32'(pop_q[0]), 1);
      chk("tie pop1 is A", 32'(pop_q[1]), 1);
      chk("tie pop2 is B", 32'(pop_q[2]), 0);
    end
    ed = '{5, 5, 5, 0, 0, 0, 0, 0};
    check_log("tie", 3, ed);

    // Downstream backpressure mid-run
    push_a(1, 0); push_a(3, 0); push_a(5, 1);
    push_b(2, 0); push_b(4, 0); push_b(6, 1);
    drive();
    #1;
    tick();
    tick();
    o_if.ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall out_data", o_if.data, 2);
      chk("stall out_valid", 32'(o_if.valid), 1);
      chk("stall a_ready", 32'(a_if.ready), 0);
      chk("stall b_ready", 32'(b_if.ready), 0);
      tick();
    end
    o_if.ready = 1'b1;
    #1;
    run_until(6, "stall");
    ed = '{1, 2, 3, 4, 5, 6, 0, 0};
    check_log("stall", 6, ed);

    // B absent in MERGE, then B drains after A's last
    b_en = 1'b0;
    push_a(1, 0); push_a(3, 1);
    push_b(6, 0); push_b(8, 1);
    drive();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("b idle a_ready", 32'(a_if.ready), 0);
      chk("b idle out_valid", 32'(o_if.valid), 0);
      tick();
    end
    b_en = 1'b1;
    drive();
    #1;
    run_until(4, "drainb");
    ed = '{1, 3, 6, 8, 0, 0, 0, 0};
    check_log("drainb", 4, ed);

    // Non-monotonic A run
    push_a(3, 0); push_a(1, 1);
    push_b(10, 1);
    drive();
    #1;
    chk("order_err before", 32'(order_err), 0);
    tick();
    chk("order_err after 3", 32'(order_err), 0);
    tick();
    chk("order_err after 1", 32'(order_err), 1);
    run_until(3, "order");
    chk("order_err sticky", 32'(order_err), 1);
    ed = '{3, 1, 10, 0, 0, 0, 0, 0};
    check_log("order", 3, ed);

    // Enable gating, then reset mid-run
    push_a(2, 0); push_a(4, 1);
    push_b(3, 0); push_b(5, 1);
    drive();
    #1;
    tick();
    ena = 1'b0;
    #1;
    chk("ena0 a_ready", 32'(a_if.ready), 0);
    chk("ena0 b_ready", 32'(b_if.ready), 0);
    chk("ena0 pending valid", 32'(o_if.valid), 1);
    tick();
    chk("ena0 drained valid", 32'(o_if.valid), 0);
    chk("ena0 a_ready 2", 32'(a_if.ready), 0);
    chk("ena0 b_ready 2", 32'(b_if.ready), 0);
    chk("ena0 one transfer", 32'(log_q.size()), 1);
    tick();
    chk("ena0 still idle", 32'(o_if.valid), 0);
    chk("ena0 still one transfer", 32'(log_q.size()), 1);
    ena = 1'b1;
    #1;
    chk("ena1 a_ready", 32'(a_if.ready), 0);
    chk("ena1 b_ready", 32'(b_if.ready), 1);
    tick();
    tick();
    chk("pre-rst out_data", o_if.data, 4);
    chk("pre-rst run_count", 32'(run_count), 2);
    chk("pre-rst order_err", 32'(order_err), 1);
    rst = 1'b1;
    #1;
    chk("in-rst a_ready", 32'(a_if.ready), 0);
    chk("in-rst b_ready", 32'(b_if.ready), 0);
    tick();
    chk("post-rst out_valid", 32'(o_if.valid), 0);
    chk("post-rst out_data", o_if.data, 0);
    chk("post-rst out_last", 32'(o_if.last), 0);
    chk("post-rst run_count", 32'(run_count), 0);
    chk("post-rst order_err", 32'(order_err), 0);
    rst = 1'b0;
    a_q.delete();
    b_q.delete();
    log_q.delete();
    pop_q.delete();
    push_a(1, 1);
    push_b(2, 1);
    drive();
    #1;
    run_until(2, "after rst");
    ed = '{1, 2, 0, 0, 0, 0, 0, 0};
    check_log("after rst", 2, ed);

    // Descending instance: A={9,2}, B={7} -> 9,7,2
    ad_if.valid = 1'b1; ad_if.data = 9; ad_if.last = 1'b0;
    bd_if.valid = 1'b1; bd_if.data = 7; bd_if.last = 1'b1;
    #1;
    chk("desc a_ready 9", 32'(ad_if.ready), 1);
    chk("desc b_ready 9", 32'(bd_if.ready), 0);
    @(posedge clk);
    #1;
    ad_if.data = 2; ad_if.last = 1'b1;
    #1;
    chk("desc out 9", od_if.data, 9);
    chk("desc valid 9", 32'(od_if.valid), 1);
    chk("desc a_ready 7", 32'(ad_if.ready), 0);
    chk("desc b_ready 7", 32'(bd_if.ready), 1);
    @(posedge clk);
    #1;
    bd_if.valid = 1'b0;
    #1;
    chk("desc out 7", od_if.data, 7);
    chk("desc a_ready 2", 32'(ad_if.ready), 1);
    @(posedge clk);
    #1;
    ad_if.valid = 1'b0;
    #1;
    chk("desc out 2", od_if.data, 2);
    chk("desc last 2", 32'(od_if.last), 1);
    chk("desc run_count 2", 32'(rcd), 2);
    @(posedge clk);
    #1;
    chk("desc run_count end", 32'(rcd), 0);
    chk("desc out_valid end", 32'(od_if.valid), 0);
    chk("desc order_err", 32'(oed), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
